// File: rtl/fp_norm_sequencer.sv
// fp_norm_sequencer: multi-cycle normalization controller that sits between
// the FP adder and the round/pack stage. It accepts one raw significand at a
// time, finds the leading one, performs a carry right-shift or bounded
// left-shifts, adjusts the exponent and raises zero/underflow/overflow flags.
module fp_norm_sequencer #(
  parameter int MAX_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_carry,
  input  logic [23:0] in_mant,
  input  logic [7:0]  in_exp,
  input  logic        in_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_mant,
  output logic [7:0]  out_exp,
  output logic        out_sign,
  output logic        out_zero,
  output logic        out_uflow,
  output logic        out_oflow
);

  // Per-cycle shift limit at the width of the remaining-shift counter.
  localparam logic [4:0] LP_MAX_SHIFT = 5'(MAX_SHIFT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Shared 24-to-5 leading-one encoder: index of the highest set bit, 0 for
  // an all-zero input (the zero case is handled separately by the caller).
  function automatic logic [4:0] f_lead_one(input logic [23:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Working registers for the operation in flight.
  state_t      r_state;
  logic [23:0] r_mant;
  logic [7:0]  r_exp;
  logic        r_sign;
  logic        r_carry;
  logic [4:0]  r_s;
  logic        r_zero;
  logic        r_uflow;
  logic        r_oflow;

  // Registered output stage, loaded only on entry to DONE.
  logic        r_out_valid;
  logic [23:0] r_out_mant;
  logic [7:0]  r_out_exp;
  logic        r_out_sign;
  logic        r_out_zero;
  logic        r_out_uflow;
  logic        r_out_oflow;

  // Next-state values.
  state_t      w_state_nxt;
  logic [23:0] w_mant_nxt;
  logic [7:0]  w_exp_nxt;
  logic        w_sign_nxt;
  logic        w_carry_nxt;
  logic [4:0]  w_s_nxt;
  logic        w_zero_nxt;
  logic        w_uflow_nxt;
  logic        w_oflow_nxt;
  logic        w_out_valid_nxt;
  logic [23:0] w_out_mant_nxt;
  logic [7:0]  w_out_exp_nxt;
  logic        w_out_sign_nxt;
  logic        w_out_zero_nxt;
  logic        w_out_uflow_nxt;
  logic        w_out_oflow_nxt;
  logic        w_load_out;

  // Leading-one position, leading-zero count and this cycle's shift step.
  logic [4:0]  w_idx;
  logic [4:0]  w_lz;
  logic [4:0]  w_step;

  assign w_idx  = f_lead_one(r_mant);
  assign w_lz   = 5'd23 - w_idx;
  assign w_step = (r_s > LP_MAX_SHIFT) ? LP_MAX_SHIFT : r_s;

  // Ready is a pure decode of the state register so it drops at the
  // acceptance edge and rises the moment reset aborts an operation.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_mant  = r_out_mant;
  assign out_exp   = r_out_exp;
  assign out_sign  = r_out_sign;
  assign out_zero  = r_out_zero;
  assign out_uflow = r_out_uflow;
  assign out_oflow = r_out_oflow;

  // Next-state and datapath decisions for every FSM state.
  always_comb begin
    w_state_nxt     = r_state;
    w_mant_nxt      = r_mant;
    w_exp_nxt       = r_exp;
    w_sign_nxt      = r_sign;
    w_carry_nxt     = r_carry;
    w_s_nxt         = r_s;
    w_zero_nxt      = r_zero;
    w_uflow_nxt     = r_uflow;
    w_oflow_nxt     = r_oflow;
    w_out_valid_nxt = r_out_valid;
    w_out_mant_nxt  = r_out_mant;
    w_out_exp_nxt   = r_out_exp;
    w_out_sign_nxt  = r_out_sign;
    w_out_zero_nxt  = r_out_zero;
    w_out_uflow_nxt = r_out_uflow;
    w_out_oflow_nxt = r_out_oflow;
    w_load_out      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_mant_nxt  = in_mant;
          w_exp_nxt   = in_exp;
          w_sign_nxt  = in_sign;
          w_carry_nxt = in_carry;
          w_s_nxt     = 5'd0;
          w_zero_nxt  = 1'b0;
          w_uflow_nxt = 1'b0;
          w_oflow_nxt = 1'b0;
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_CHECK: begin
        if (r_carry) begin
          // Carry-out: single right shift, never enters SHIFT.
          w_s_nxt = 5'd0;
          if (r_exp < 8'd254) begin
            w_mant_nxt = {1'b1, r_mant[23:1]};
            w_exp_nxt  = r_exp + 8'd1;
          end else begin
            w_mant_nxt  = 24'd0;
            w_exp_nxt   = 8'd255;
            w_oflow_nxt = 1'b1;
          end
        end else if (r_mant == 24'd0) begin
          w_s_nxt    = 5'd0;
          w_exp_nxt  = 8'd0;
          w_zero_nxt = 1'b1;
        end else if ({3'b000, w_lz} < r_exp) begin
          w_s_nxt   = w_lz;
          w_exp_nxt = r_exp - {3'b000, w_lz};
        end else begin
          // Exponent cannot absorb the full shift: denormalize to exp 0.
          // Here r_exp <= 23, so its low five bits hold the whole value.
          w_s_nxt     = (r_exp == 8'd0) ? 5'd0 : (r_exp[4:0] - 5'd1);
          w_exp_nxt   = 8'd0;
          w_uflow_nxt = 1'b1;
        end

        if (w_s_nxt == 5'd0) begin
          w_state_nxt = S_DONE;
          w_load_out  = 1'b1;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_mant_nxt = r_mant << w_step;
        w_s_nxt    = r_s - w_step;
        if (w_s_nxt == 5'd0) begin
          w_state_nxt = S_DONE;
          w_load_out  = 1'b1;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_out_zero_nxt  = 1'b0;
          w_out_uflow_nxt = 1'b0;
          w_out_oflow_nxt = 1'b0;
        end else begin
          w_state_nxt = S_DONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Output stage captures the final result only on entry to DONE.
    if (w_load_out) begin
      w_out_valid_nxt = 1'b1;
      w_out_mant_nxt  = w_mant_nxt;
      w_out_exp_nxt   = w_exp_nxt;
      w_out_sign_nxt  = w_sign_nxt;
      w_out_zero_nxt  = w_zero_nxt;
      w_out_uflow_nxt = w_uflow_nxt;
      w_out_oflow_nxt = w_oflow_nxt;
    end else begin
      w_out_valid_nxt = w_out_valid_nxt;
    end
  end

  // State, working and output registers; reset discards any operand in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mant      <= 24'd0;
      r_exp       <= 8'd0;
      r_sign      <= 1'b0;
      r_carry     <= 1'b0;
      r_s         <= 5'd0;
      r_zero      <= 1'b0;
      r_uflow     <= 1'b0;
      r_oflow     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_mant  <= 24'd0;
      r_out_exp   <= 8'd0;
      r_out_sign  <= 1'b0;
      r_out_zero  <= 1'b0;
      r_out_uflow <= 1'b0;
      r_out_oflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mant      <= w_mant_nxt;
      r_exp       <= w_exp_nxt;
      r_sign      <= w_sign_nxt;
      r_carry     <= w_carry_nxt;
      r_s         <= w_s_nxt;
      r_zero      <= w_zero_nxt;
      r_uflow     <= w_uflow_nxt;
      r_oflow     <= w_oflow_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_mant  <= w_out_mant_nxt;
      r_out_exp   <= w_out_exp_nxt;
      r_out_sign  <= w_out_sign_nxt;
      r_out_zero  <= w_out_zero_nxt;
      r_out_uflow <= w_out_uflow_nxt;
      r_out_oflow <= w_out_oflow_nxt;
    end
  end

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Directed testbench for fp_norm_sequencer (MAX_SHIFT = 8).
module tb_fp_norm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_carry;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_uflow;
  logic        out_oflow;

  int n_vec = 0;
  int n_err = 0;

  fp_norm_sequencer #(.MAX_SHIFT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_carry  (in_carry),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_uflow (out_uflow),
    .out_oflow (out_oflow)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present one operand, wait for acceptance, then count cycles to out_valid.
  task automatic run_op(input logic [23:0] m, input logic [7:0] e, input logic c,
                        input logic sg, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    in_carry = c;
    in_sign  = sg;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", {31'd0, in_ready}, 32'd0);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_res(input string tag, input int lat, input int lat_exp,
                           input logic [23:0] m, input logic [7:0] e, input logic sg,
                           input logic z, input logic u, input logic o);
    chk({tag, "_lat"},   lat, lat_exp);
    chk({tag, "_mant"},  {8'd0, out_mant}, {8'd0, m});
    chk({tag, "_exp"},   {24'd0, out_exp}, {24'd0, e});
    chk({tag, "_sign"},  {31'd0, out_sign}, {31'd0, sg});
    chk({tag, "_flags"}, {29'd0, out_zero, out_uflow, out_oflow}, {29'd0, z, u, o});
  endtask

  // Complete the output handshake and confirm the block is free again.
  task automatic accept(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ready"},  {31'd0, in_ready}, 32'd1);
    chk({tag, "_vclr"},   {31'd0, out_valid}, 32'd0);
    chk({tag, "_fclr"},   {29'd0, out_zero, out_uflow, out_oflow}, 32'd0);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_carry  = 1'b0;
    in_mant   = 24'd0;
    in_exp    = 8'd0;
    in_sign   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mant",  {8'd0, out_mant}, 32'd0);
    chk("rst_exp",   {24'd0, out_exp}, 32'd0);
    chk("rst_flags", {28'd0, out_sign, out_zero, out_uflow, out_oflow}, 32'd0);

    // Full 23-bit shift: 1 + ceil(23/8) = 4.
    run_op(24'h000001, 8'd100, 1'b0, 1'b1, lat);
    check_res("s23", lat, 4, 24'h800000, 8'd77, 1'b1, 1'b0, 1'b0, 1'b0);
    accept("s23");

    // Carry path.
    run_op(24'hC00000, 8'd10, 1'b1, 1'b0, lat);
    check_res("carry", lat, 1, 24'hE00000, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    accept("carry");

    // Carry just below overflow threshold.
    run_op(24'h800001, 8'd253, 1'b1, 1'b1, lat);
    check_res("carry253", lat, 1, 24'hC00000, 8'd254, 1'b1, 1'b0, 1'b0, 1'b0);
    accept("carry253");

    // Carry overflow.
    run_op(24'h123456, 8'd254, 1'b1, 1'b0, lat);
    check_res("oflow", lat, 1, 24'h000000, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1);
    accept("oflow");

    // Underflow: lz=15 >= exp=5, s=4.
    run_op(24'h000100, 8'd5, 1'b0, 1'b0, lat);
    check_res("uflow", lat, 2, 24'h001000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    accept("uflow");

    // Underflow boundary lz == exp: lz=8, exp=8, s=7.
    run_op(24'h008000, 8'd8, 1'b0, 1'b1, lat);
    check_res("lzeq", lat, 2, 24'h400000, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    accept("lzeq");

    // Underflow with exp=0: no shift.
    run_op(24'h000010, 8'd0, 1'b0, 1'b0, lat);
    check_res("exp0", lat, 1, 24'h000010, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    accept("exp0");

    // Zero significand.
    run_op(24'h000000, 8'd77, 1'b0, 1'b1, lat);
    check_res("zero", lat, 1, 24'h000000, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    accept("zero");

    // Backpressure: hold out_ready low three cycles in DONE.
    run_op(24'h400000, 8'd50, 1'b0, 1'b0, lat);
    check_res("hold", lat, 2, 24'h800000, 8'd49, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_mant",  {8'd0, out_mant}, 32'h00800000);
      chk("hold_exp",   {24'd0, out_exp}, 32'd49);
    end
    accept("hold");

    // Back-to-back operand: lz=12, s=12 -> 1 + 2 = 3.
    run_op(24'h000F00, 8'd200, 1'b0, 1'b1, lat);
    check_res("b2b", lat, 3, 24'hF00000, 8'd188, 1'b1, 1'b0, 1'b0, 1'b0);
    accept("b2b");

    // Reset pulse during SHIFT.
    @(negedge clk);
    in_valid = 1'b1;
    in_mant  = 24'h000001;
    in_exp   = 8'd100;
    in_carry = 1'b0;
    in_sign  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst_n = 1'b1;

    // Normal operation after the abort: lz=22 -> 1 + 3 = 4.
    run_op(24'h000003, 8'd40, 1'b0, 1'b0, lat);
    check_res("post_rst", lat, 4, 24'hC00000, 8'd18, 1'b0, 1'b0, 1'b0, 1'b0);
    accept("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
